// File: rtl/usb_xact_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : usb_xact_ctrl
// Description : Device-side USB transaction controller. Chooses handshake or
//               data PID per transaction and tracks per-endpoint data toggles.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_xact_ctrl #(
    parameter int NUM_EP      = 4,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_pid_en,
    input  logic [3:0]        rx_pid,
    input  logic [3:0]        rx_endp,
    input  logic              crc5_err,
    input  logic              rx_data_done,
    input  logic [3:0]        rx_data_pid,
    input  logic              rx_data_crc_ok,
    input  logic [NUM_EP-1:0] ep_stall,
    input  logic [NUM_EP-1:0] ep_out_ready,
    input  logic [NUM_EP-1:0] ep_in_valid,
    output logic              tx_req,
    output logic [3:0]        tx_pid,
    output logic              tx_is_data,
    input  logic              tx_ack,
    input  logic              tx_done,
    output logic              rx_handshake_on,
    output logic              xfer_done,
    output logic [3:0]        xfer_endp,
    output logic              xfer_dir,
    output logic              xfer_setup
);

    localparam logic [3:0] c_PID_OUT   = 4'b0001;
    localparam logic [3:0] c_PID_IN    = 4'b1001;
    localparam logic [3:0] c_PID_SETUP = 4'b1101;
    localparam logic [3:0] c_PID_DATA0 = 4'b0011;
    localparam logic [3:0] c_PID_DATA1 = 4'b1011;
    localparam logic [3:0] c_PID_ACK   = 4'b0010;
    localparam logic [3:0] c_PID_NAK   = 4'b1010;
    localparam logic [3:0] c_PID_STALL = 4'b1110;

    localparam int              c_TW     = $clog2(TIMEOUT_CYC);
    localparam int              c_EPW    = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;
    localparam logic [c_TW-1:0] c_T_LAST = c_TW'(TIMEOUT_CYC - 1);
    localparam logic [4:0]      c_NUM_EP = 5'(NUM_EP);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_RX_DATA   = 3'd1;
    localparam logic [2:0] c_HS_SEND   = 3'd2;
    localparam logic [2:0] c_HS_WAIT   = 3'd3;
    localparam logic [2:0] c_DATA_SEND = 3'd4;
    localparam logic [2:0] c_DATA_WAIT = 3'd5;
    localparam logic [2:0] c_ACK_WAIT  = 3'd6;

    logic [2:0]        r_state;
    logic [c_TW-1:0]   r_timer;
    logic [3:0]        r_endp;
    logic              r_is_setup;
    logic [NUM_EP-1:0] r_tog_out;
    logic [NUM_EP-1:0] r_tog_in;
    logic              r_tx_req;
    logic [3:0]        r_tx_pid;
    logic              r_tx_is_data;
    logic              r_hs_on;
    logic              r_xfer_done;
    logic [3:0]        r_xfer_endp;
    logic              r_xfer_dir;
    logic              r_xfer_setup;

    logic             w_tok_valid;
    logic             w_data_pid_ok;
    logic             w_data_tog;
    logic [c_EPW-1:0] w_tok_ep;
    logic [c_EPW-1:0] w_cur_ep;

    assign w_tok_valid   = rx_pid_en && !crc5_err &&
                           (rx_pid == c_PID_OUT || rx_pid == c_PID_IN || rx_pid == c_PID_SETUP) &&
                           ({1'b0, rx_endp} < c_NUM_EP);
    assign w_data_pid_ok = (rx_data_pid == c_PID_DATA0) || (rx_data_pid == c_PID_DATA1);
    assign w_data_tog    = (rx_data_pid == c_PID_DATA1);
    assign w_tok_ep      = rx_endp[c_EPW-1:0];
    assign w_cur_ep      = r_endp[c_EPW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_timer      <= '0;
            r_endp       <= '0;
            r_is_setup   <= 1'b0;
            r_tog_out    <= '0;
            r_tog_in     <= '0;
            r_tx_req     <= 1'b0;
            r_tx_pid     <= '0;
            r_tx_is_data <= 1'b0;
            r_hs_on      <= 1'b0;
            r_xfer_done  <= 1'b0;
            r_xfer_endp  <= '0;
            r_xfer_dir   <= 1'b0;
            r_xfer_setup <= 1'b0;
        end else begin
            r_xfer_done <= 1'b0;
            // Data completion outranks a token arriving in the same cycle
            if (r_state == c_RX_DATA && rx_data_done) begin
                if (!rx_data_crc_ok || !w_data_pid_ok ||
                    (r_is_setup && rx_data_pid != c_PID_DATA0)) begin
                    r_state <= c_IDLE;
                end else begin
                    r_state      <= c_HS_SEND;
                    r_tx_req     <= 1'b1;
                    r_tx_is_data <= 1'b0;
                    r_tx_pid     <= c_PID_ACK;
                    if (r_is_setup) begin
                        r_tog_out[w_cur_ep] <= 1'b1;
                        r_tog_in[w_cur_ep]  <= 1'b1;
                        r_xfer_done         <= 1'b1;
                        r_xfer_endp         <= r_endp;
                        r_xfer_dir          <= 1'b0;
                        r_xfer_setup        <= 1'b1;
                    end else if (ep_stall[w_cur_ep]) begin
                        r_tx_pid <= c_PID_STALL;
                    end else if (!ep_out_ready[w_cur_ep]) begin
                        r_tx_pid <= c_PID_NAK;
                    end else if (w_data_tog == r_tog_out[w_cur_ep]) begin
                        r_tog_out[w_cur_ep] <= ~r_tog_out[w_cur_ep];
                        r_xfer_done         <= 1'b1;
                        r_xfer_endp         <= r_endp;
                        r_xfer_dir          <= 1'b0;
                        r_xfer_setup        <= 1'b0;
                    end
                end
            end else if ((r_state == c_IDLE || r_state == c_RX_DATA) && w_tok_valid) begin
                r_endp     <= rx_endp;
                r_is_setup <= (rx_pid == c_PID_SETUP);
                r_timer    <= '0;
                if (rx_pid == c_PID_IN) begin
                    r_tx_req <= 1'b1;
                    if (ep_stall[w_tok_ep]) begin
                        r_state      <= c_HS_SEND;
                        r_tx_pid     <= c_PID_STALL;
                        r_tx_is_data <= 1'b0;
                    end else if (!ep_in_valid[w_tok_ep]) begin
                        r_state      <= c_HS_SEND;
                        r_tx_pid     <= c_PID_NAK;
                        r_tx_is_data <= 1'b0;
                    end else begin
                        r_state      <= c_DATA_SEND;
                        r_tx_pid     <= r_tog_in[w_tok_ep] ? c_PID_DATA1 : c_PID_DATA0;
                        r_tx_is_data <= 1'b1;
                    end
                end else begin
                    r_state <= c_RX_DATA;
                end
            end else begin
                case (r_state)
                    c_RX_DATA: begin
                        if (r_timer == c_T_LAST) r_state <= c_IDLE;
                        else                     r_timer <= r_timer + 1'b1;
                    end
                    c_HS_SEND, c_DATA_SEND: begin
                        if (tx_ack) begin
                            r_tx_req <= 1'b0;
                            r_state  <= (r_state == c_HS_SEND) ? c_HS_WAIT : c_DATA_WAIT;
                        end
                    end
                    c_HS_WAIT: begin
                        if (tx_done) r_state <= c_IDLE;
                    end
                    c_DATA_WAIT: begin
                        if (tx_done) begin
                            r_state <= c_ACK_WAIT;
                            r_timer <= '0;
                            r_hs_on <= 1'b1;
                        end
                    end
                    c_ACK_WAIT: begin
                        // Any handshake ends the wait; only ACK commits the IN data
                        if (rx_pid_en) begin
                            r_state <= c_IDLE;
                            r_hs_on <= 1'b0;
                            if (rx_pid == c_PID_ACK) begin
                                r_tog_in[w_cur_ep] <= ~r_tog_in[w_cur_ep];
                                r_xfer_done        <= 1'b1;
                                r_xfer_endp        <= r_endp;
                                r_xfer_dir         <= 1'b1;
                                r_xfer_setup       <= 1'b0;
                            end
                        end else if (r_timer == c_T_LAST) begin
                            r_state <= c_IDLE;
                            r_hs_on <= 1'b0;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                    default: r_state <= c_IDLE;
                endcase
            end
        end
    end

    assign tx_req          = r_tx_req;
    assign tx_pid          = r_tx_pid;
    assign tx_is_data      = r_tx_is_data;
    assign rx_handshake_on = r_hs_on;
    assign xfer_done       = r_xfer_done;
    assign xfer_endp       = r_xfer_endp;
    assign xfer_dir        = r_xfer_dir;
    assign xfer_setup      = r_xfer_setup;

endmodule
`default_nettype wire

// File: tb/tb_usb_xact_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_xact_ctrl
// Description : Randomized transaction-level bench for usb_xact_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_xact_ctrl;

    localparam int NUM_EP      = 4;
    localparam int TIMEOUT_CYC = 16;

    localparam logic [3:0] c_OUT   = 4'b0001;
    localparam logic [3:0] c_IN    = 4'b1001;
    localparam logic [3:0] c_SETUP = 4'b1101;
    localparam logic [3:0] c_SOF   = 4'b0101;
    localparam logic [3:0] c_DATA0 = 4'b0011;
    localparam logic [3:0] c_DATA1 = 4'b1011;
    localparam logic [3:0] c_ACK   = 4'b0010;
    localparam logic [3:0] c_NAK   = 4'b1010;
    localparam logic [3:0] c_STALL = 4'b1110;

    logic              clk = 1'b0;
    logic              rst;
    logic              rx_pid_en;
    logic [3:0]        rx_pid;
    logic [3:0]        rx_endp;
    logic              crc5_err;
    logic              rx_data_done;
    logic [3:0]        rx_data_pid;
    logic              rx_data_crc_ok;
    logic [NUM_EP-1:0] ep_stall;
    logic [NUM_EP-1:0] ep_out_ready;
    logic [NUM_EP-1:0] ep_in_valid;
    logic              tx_req;
    logic [3:0]        tx_pid;
    logic              tx_is_data;
    logic              tx_ack;
    logic              tx_done;
    logic              rx_handshake_on;
    logic              xfer_done;
    logic [3:0]        xfer_endp;
    logic              xfer_dir;
    logic              xfer_setup;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: per-endpoint toggles plus expected/observed commit events
    bit         m_tog_out [NUM_EP];
    bit         m_tog_in  [NUM_EP];
    logic [5:0] exp_q [$];
    logic [5:0] act_q [$];

    always #5 clk = ~clk;

    usb_xact_ctrl #(.NUM_EP(NUM_EP), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_pid_en      (rx_pid_en),
        .rx_pid         (rx_pid),
        .rx_endp        (rx_endp),
        .crc5_err       (crc5_err),
        .rx_data_done   (rx_data_done),
        .rx_data_pid    (rx_data_pid),
        .rx_data_crc_ok (rx_data_crc_ok),
        .ep_stall       (ep_stall),
        .ep_out_ready   (ep_out_ready),
        .ep_in_valid    (ep_in_valid),
        .tx_req         (tx_req),
        .tx_pid         (tx_pid),
        .tx_is_data     (tx_is_data),
        .tx_ack         (tx_ack),
        .tx_done        (tx_done),
        .rx_handshake_on(rx_handshake_on),
        .xfer_done      (xfer_done),
        .xfer_endp      (xfer_endp),
        .xfer_dir       (xfer_dir),
        .xfer_setup     (xfer_setup)
    );

    always @(negedge clk) begin
        if (!rst && xfer_done === 1'b1) act_q.push_back({xfer_endp, xfer_dir, xfer_setup});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_xfers;
        chk("xfer_cnt", 32'(act_q.size()), 32'(exp_q.size()));
        while (act_q.size() > 0 && exp_q.size() > 0)
            chk("xfer_info", 32'(act_q.pop_front()), 32'(exp_q.pop_front()));
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic send_token(input logic [3:0] pid, input int ep, input bit crc_bad);
        rx_pid_en = 1'b1;
        rx_pid    = pid;
        rx_endp   = 4'(ep);
        crc5_err  = crc_bad;
        tick;
        rx_pid_en = 1'b0;
        crc5_err  = 1'b0;
    endtask

    task automatic expect_silence;
        logic seen;
        seen = 1'b0;
        repeat (3) begin
            seen = seen | tx_req;
            tick;
        end
        chk("no_tx", 32'(seen), 0);
    endtask

    task automatic serve_tx(input logic [3:0] pid, input logic is_data);
        int n;
        n = 0;
        while (tx_req !== 1'b1 && n < 8) begin
            tick;
            n++;
        end
        chk("tx_req", 32'(tx_req), 1);
        if (tx_req !== 1'b1) return;
        chk("tx_pid", 32'(tx_pid), 32'(pid));
        chk("tx_is_data", 32'(tx_is_data), 32'(is_data));
        chk("hs_off_tx", 32'(rx_handshake_on), 0);
        repeat ($urandom_range(0, 2)) tick;
        tx_ack = 1'b1;
        tick;
        tx_ack = 1'b0;
        chk("tx_req_drop", 32'(tx_req), 0);
        repeat ($urandom_range(0, 3)) tick;
        tx_done = 1'b1;
        tick;
        tx_done = 1'b0;
    endtask

    task automatic do_out(input bit setup, input int ep, input bit crc_bad, input bit stall,
                          input bit ready, input logic [3:0] dpid, input bit crc_ok, input int dly);
        bit         valid;
        bit         reply;
        logic [3:0] rpid;
        valid = !crc_bad && ep < NUM_EP;
        ep_stall     = NUM_EP'($urandom);
        ep_out_ready = NUM_EP'($urandom);
        if (ep < NUM_EP) begin
            ep_stall[ep]     = stall;
            ep_out_ready[ep] = ready;
        end
        send_token(setup ? c_SETUP : c_OUT, ep, crc_bad);
        chk("rx_txreq", 32'(tx_req), 0);
        repeat (dly) tick;
        rx_data_done   = 1'b1;
        rx_data_pid    = dpid;
        rx_data_crc_ok = crc_ok;
        tick;
        rx_data_done = 1'b0;
        reply = 1'b0;
        rpid  = c_ACK;
        // Data arriving after TIMEOUT_CYC waiting cycles finds the controller idle
        if (valid && dly < TIMEOUT_CYC && crc_ok && (dpid == c_DATA0 || dpid == c_DATA1)) begin
            if (setup) begin
                if (dpid == c_DATA0) begin
                    reply = 1'b1;
                    m_tog_out[ep] = 1'b1;
                    m_tog_in[ep]  = 1'b1;
                    exp_q.push_back({4'(ep), 1'b0, 1'b1});
                end
            end else if (stall) begin
                reply = 1'b1;
                rpid  = c_STALL;
            end else if (!ready) begin
                reply = 1'b1;
                rpid  = c_NAK;
            end else begin
                reply = 1'b1;
                if ((dpid == c_DATA1) == m_tog_out[ep]) begin
                    m_tog_out[ep] = !m_tog_out[ep];
                    exp_q.push_back({4'(ep), 1'b0, 1'b0});
                end
            end
        end
        if (reply) serve_tx(rpid, 1'b0);
        else       expect_silence();
        tick;
        chk("hs_idle", 32'(rx_handshake_on), 0);
        check_xfers();
    endtask

    // resp: 0 host ACK, 1 other handshake, 2 no answer
    task automatic do_in(input int ep, input bit crc_bad, input bit stall, input bit avail, input int resp);
        ep_stall    = NUM_EP'($urandom);
        ep_in_valid = NUM_EP'($urandom);
        if (ep < NUM_EP) begin
            ep_stall[ep]    = stall;
            ep_in_valid[ep] = avail;
        end
        send_token(c_IN, ep, crc_bad);
        if (crc_bad || ep >= NUM_EP) expect_silence();
        else if (stall)              serve_tx(c_STALL, 1'b0);
        else if (!avail)             serve_tx(c_NAK, 1'b0);
        else begin
            serve_tx(m_tog_in[ep] ? c_DATA1 : c_DATA0, 1'b1);
            chk("hs_on", 32'(rx_handshake_on), 1);
            if (resp == 2) begin
                repeat (TIMEOUT_CYC - 1) tick;
                chk("hs_on_last", 32'(rx_handshake_on), 1);
                tick;
                chk("hs_timeout", 32'(rx_handshake_on), 0);
            end else begin
                repeat ($urandom_range(0, 3)) tick;
                rx_pid_en = 1'b1;
                rx_pid    = (resp == 0) ? c_ACK : c_NAK;
                rx_endp   = 4'($urandom);
                tick;
                rx_pid_en = 1'b0;
                chk("hs_release", 32'(rx_handshake_on), 0);
                if (resp == 0) begin
                    m_tog_in[ep] = !m_tog_in[ep];
                    exp_q.push_back({4'(ep), 1'b1, 1'b0});
                end
            end
        end
        tick;
        chk("hs_idle", 32'(rx_handshake_on), 0);
        check_xfers();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "simulation stuck");
    end

    initial begin
        rst = 1'b1;
        rx_pid_en = 1'b0; rx_pid = '0; rx_endp = '0; crc5_err = 1'b0;
        rx_data_done = 1'b0; rx_data_pid = '0; rx_data_crc_ok = 1'b0;
        ep_stall = '0; ep_out_ready = '0; ep_in_valid = '0;
        tx_ack = 1'b0; tx_done = 1'b0;
        foreach (m_tog_out[i]) begin
            m_tog_out[i] = 1'b0;
            m_tog_in[i]  = 1'b0;
        end
        repeat (3) tick;
        chk("rst_tx_req", 32'(tx_req), 0);
        chk("rst_tx_pid", 32'(tx_pid), 0);
        chk("rst_tx_is_data", 32'(tx_is_data), 0);
        chk("rst_hs_on", 32'(rx_handshake_on), 0);
        chk("rst_xfer_done", 32'(xfer_done), 0);
        chk("rst_xfer_endp", 32'(xfer_endp), 0);
        chk("rst_xfer_dir", 32'(xfer_dir), 0);
        chk("rst_xfer_setup", 32'(xfer_setup), 0);
        rst = 1'b0;
        tick;

        do_out(1'b1, 0, 1'b0, 1'b0, 1'b1, c_DATA0, 1'b1, 1);
        do_in(0, 1'b0, 1'b0, 1'b1, 0);
        do_out(1'b0, 1, 1'b0, 1'b0, 1'b1, c_DATA0, 1'b1, 0);
        do_out(1'b0, 1, 1'b0, 1'b0, 1'b1, c_DATA0, 1'b1, 0);
        do_in(2, 1'b0, 1'b0, 1'b1, 0);
        do_in(2, 1'b0, 1'b0, 1'b1, 0);
        do_in(2, 1'b0, 1'b0, 1'b1, 2);
        do_in(2, 1'b0, 1'b0, 1'b1, 0);
        do_out(1'b0, 3, 1'b0, 1'b1, 1'b1, c_DATA0, 1'b1, 0);
        do_out(1'b0, 3, 1'b0, 1'b0, 1'b0, c_DATA0, 1'b1, 0);
        do_out(1'b0, 3, 1'b1, 1'b0, 1'b1, c_DATA0, 1'b1, 0);
        do_out(1'b0, 5, 1'b0, 1'b0, 1'b1, c_DATA0, 1'b1, 0);
        do_out(1'b0, 3, 1'b0, 1'b0, 1'b1, c_DATA0, 1'b1, TIMEOUT_CYC - 1);
        do_out(1'b0, 3, 1'b0, 1'b0, 1'b1, c_DATA1, 1'b1, TIMEOUT_CYC);
        do_out(1'b1, 1, 1'b0, 1'b0, 1'b1, c_DATA1, 1'b1, 0);
        send_token(c_SOF, 0, 1'b0);
        expect_silence();
        send_token(c_OUT, 1, 1'b0);
        tick;
        do_in(2, 1'b0, 1'b0, 1'b1, 0);

        for (int i = 0; i < 80; i++) begin
            int         ep;
            int         r;
            int         dly;
            logic [3:0] dpid;
            ep = ($urandom_range(0, 7) == 0) ? int'(4 + $urandom_range(0, 11)) : int'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                r = int'($urandom_range(0, 9));
                do_in(ep, $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0,
                      $urandom_range(0, 4) != 0, (r < 7) ? 0 : (r < 9) ? 1 : 2);
            end else begin
                r    = int'($urandom_range(0, 9));
                dly  = (r == 8) ? TIMEOUT_CYC - 1 : (r == 9) ? TIMEOUT_CYC : int'($urandom_range(0, 3));
                r    = int'($urandom_range(0, 9));
                dpid = (r == 0) ? c_SOF : ($urandom_range(0, 1) == 1) ? c_DATA1 : c_DATA0;
                do_out($urandom_range(0, 3) == 0, ep, $urandom_range(0, 9) == 0,
                       $urandom_range(0, 5) == 0, $urandom_range(0, 4) != 0,
                       dpid, $urandom_range(0, 9) != 0, dly);
            end
        end

        // Reset while a data packet is being requested
        if (!m_tog_in[2]) do_in(2, 1'b0, 1'b0, 1'b1, 0);
        ep_stall    = '0;
        ep_in_valid = '1;
        send_token(c_IN, 2, 1'b0);
        chk("pre_rst_req", 32'(tx_req), 1);
        chk("pre_rst_pid", 32'(tx_pid), 32'(c_DATA1));
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rst_mid_req", 32'(tx_req), 0);
        chk("rst_mid_pid", 32'(tx_pid), 0);
        chk("rst_mid_is_data", 32'(tx_is_data), 0);
        foreach (m_tog_out[i]) begin
            m_tog_out[i] = 1'b0;
            m_tog_in[i]  = 1'b0;
        end
        act_q.delete();
        exp_q.delete();
        tick;
        do_in(2, 1'b0, 1'b0, 1'b1, 0);
        do_out(1'b0, 0, 1'b0, 1'b0, 1'b1, c_DATA0, 1'b1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
